// File: rtl/uart_pkg.sv
// Shared types and defaults for the queue-draining UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_baud_tick.sv
// Restartable bit-period counter: tick marks the last clk of each bit period.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/queue_uart_tx.sv
// Drains a byte queue and serializes each entry as an 8N1 frame, LSB first,
// chaining frames back-to-back while the queue stays non-empty.
module queue_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] q_data,
    input  logic                  q_empty,
    output logic                  q_remove,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           sent_count
);

    localparam int IDX_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_WIDTH - 1);

    tx_state_t             state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [IDX_W-1:0]      bit_idx;
    logic                  bit_tick;
    logic                  armed;
    logic                  pop;

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (pop),
        .tick  (bit_tick)
    );

    // armed keeps the pop strobe low while reset is held, without a
    // combinational path from rst_n to q_remove.
    assign pop        = armed & enable & ~q_empty &
                        ((state == IDLE) | ((state == STOP) & bit_tick));
    assign q_remove   = pop;
    assign busy       = (state != IDLE);
    assign frame_done = (state == STOP) & bit_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_idx    <= '0;
            tx         <= 1'b1;
            sent_count <= '0;
            armed      <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (frame_done)
                sent_count <= sent_count + 16'd1;

            case (state)
                START: if (bit_tick) begin
                    state   <= DATA;
                    bit_idx <= '0;
                    tx      <= shreg[0];
                end
                DATA: if (bit_tick) begin
                    shreg   <= shreg >> 1;
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == LAST_BIT) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        tx    <= shreg[1];
                    end
                end
                STOP: if (bit_tick)
                    state <= IDLE;
                default: ;
            endcase

            // A pop overrides the STOP->IDLE return so frames chain with no gap.
            if (pop) begin
                shreg <= q_data;
                state <= START;
                tx    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_queue_uart_tx.sv
// Bench for queue_uart_tx: queue model, line-decoding scoreboard, frame vectors.
module tb_queue_uart_tx;

    localparam int CPB   = 4;
    localparam int DW    = 8;
    localparam int FRAME = (DW + 2) * CPB;

    logic        clk = 1'b0;
    logic        rst_n, enable, q_empty, q_remove, tx, busy, frame_done;
    logic [7:0]  q_data;
    logic [15:0] sent_count;

    always #5 clk = ~clk;

    queue_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .q_data     (q_data),
        .q_empty    (q_empty),
        .q_remove   (q_remove),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done),
        .sent_count (sent_count)
    );

    // Queue model: tail advanced by the stimulus, head by committed pops.
    logic [7:0] qmem [64];
    logic [5:0] head = '0;
    logic [5:0] tail = '0;
    assign q_data  = qmem[head];
    assign q_empty = (head == tail);
    always @(posedge clk) if (q_remove && !q_empty) head <= head + 6'd1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Scoreboard: popped bytes in, decoded line frames out.
    logic [7:0] exp_q [$];
    int         rx_frames = 0;
    bit         rx_active = 1'b0;
    int         rx_cnt    = 0;
    logic [9:0] rx_bits;

    always @(posedge clk) if (rst_n && q_remove && !q_empty) exp_q.push_back(q_data);

    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst_n) begin
            if (rx_active && exp_q.size() > 0) e = exp_q.pop_front();
            rx_active = 1'b0;
        end else begin
            if (!rx_active && tx == 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
            end else if (rx_active) begin
                rx_cnt++;
            end
            if (rx_active && (rx_cnt % CPB) == CPB / 2) begin
                rx_bits[rx_cnt / CPB] = tx;
                if (rx_cnt / CPB == DW + 1) begin
                    rx_active = 1'b0;
                    rx_frames++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL sb_unexpected_frame at %0t: got 0x%0h, expected none", $time, rx_bits[8:1]);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_byte", rx_bits[8:1], e);
                        check("sb_stop", rx_bits[9], 1);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        qmem[tail] = d;
        tail = tail + 6'd1;
    endtask

    task automatic wait_pop(input int bound, output bit ok);
        #1;
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            if (q_remove) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("pop_seen", ok, 1);
    endtask

    function automatic logic [9:0] fr(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    // Called in the pop cycle; walks the following frame cycle by cycle.
    task automatic check_frame(input logic [9:0] frame, input logic exp_next_pop, input int drop_at);
        int busy_bad = 0;
        int fd_bad   = 0;
        for (int i = 1; i <= FRAME; i++) begin
            tick();
            if ((i - 1) % CPB == CPB / 2)
                check($sformatf("tx_bit%0d", (i - 1) / CPB), tx, frame[(i - 1) / CPB]);
            if (!busy) busy_bad++;
            if (i < FRAME && frame_done) fd_bad++;
            if (i == drop_at) enable = 1'b0;
        end
        check("frame_done_last", frame_done, 1);
        check("next_pop", q_remove, exp_next_pop);
        check("busy_gaps", busy_bad, 0);
        check("frame_done_early", fd_bad, 0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vt [4];

    initial begin
        bit ok;
        int viol;
        int exp_sent;

        vt[0] = '{8'hA5, 10'b1_10100101_0};
        vt[1] = '{8'h3C, 10'b1_00111100_0};
        vt[2] = '{8'h00, 10'b1_00000000_0};
        vt[3] = '{8'hFF, 10'b1_11111111_0};

        // Reset held with work pending
        rst_n  = 1'b0;
        enable = 1'b1;
        push(8'h5A);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_tx", tx, 1);
            check("rst_busy", busy, 0);
            check("rst_q_remove", q_remove, 0);
            check("rst_frame_done", frame_done, 0);
            check("rst_sent_count", sent_count, 0);
        end
        rst_n = 1'b1;
        wait_pop(3, ok);
        if (ok) check_frame(fr(8'h5A), 1'b0, 0);
        exp_sent = 1;
        tick();
        check("sent_count", sent_count, exp_sent);
        check("idle_busy", busy, 0);

        // Single-byte frames from the vector table
        for (int v = 0; v < 4; v++) begin
            push(vt[v].data);
            wait_pop(3, ok);
            if (ok) check_frame(vt[v].frame, 1'b0, 0);
            exp_sent++;
            tick();
            check("sent_count", sent_count, exp_sent);
            check("idle_busy", busy, 0);
            check("idle_tx", tx, 1);
        end

        // Back-to-back
        push(8'h01);
        push(8'h80);
        push(8'hFF);
        wait_pop(3, ok);
        if (ok) begin
            check_frame(fr(8'h01), 1'b1, 0);
            check_frame(fr(8'h80), 1'b1, 0);
            check_frame(fr(8'hFF), 1'b0, 0);
        end
        exp_sent += 3;
        tick();
        check("b2b_sent_count", sent_count, exp_sent);

        // Empty queue
        viol = 0;
        repeat (200) begin
            tick();
            if (q_remove || !tx || busy) viol++;
        end
        check("empty_idle_violations", viol, 0);

        // Enable dropped in data bit 2
        push(8'hC3);
        push(8'h99);
        wait_pop(3, ok);
        if (ok) check_frame(fr(8'hC3), 1'b0, CPB + 2 * CPB + 2);
        exp_sent++;
        tick();
        check("drop_sent_count", sent_count, exp_sent);
        viol = 0;
        repeat (10) begin
            tick();
            if (q_remove || busy || !tx) viol++;
        end
        check("disabled_violations", viol, 0);
        enable = 1'b1;
        wait_pop(2, ok);
        if (ok) check_frame(fr(8'h99), 1'b0, 0);
        exp_sent++;
        tick();
        check("reenable_sent_count", sent_count, exp_sent);

        // Reset during data bit 3
        push(8'h3C);
        wait_pop(3, ok);
        repeat (CPB + 3 * CPB + 2) tick();
        push(8'h77);
        rst_n = 1'b0;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_sent_count", sent_count, 0);
        repeat (3) begin
            tick();
            check("midrst_q_remove", q_remove, 0);
        end
        rst_n = 1'b1;
        wait_pop(3, ok);
        if (ok) check_frame(fr(8'h77), 1'b0, 0);
        exp_sent = 1;
        tick();
        check("post_rst_sent_count", sent_count, exp_sent);

        tick();
        tick();
        check("sb_leftover", exp_q.size(), 0);
        check("rx_frames", rx_frames, 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog at %0t: bench did not finish", $time);
        $fatal(1);
    end

endmodule

// File: doc/queue_uart_tx.md
# queue_uart_tx

Byte-serial transmitter that drains a circular byte queue and emits each entry as an 8N1 UART frame on a single `tx` line. It is the consuming end of the queue: it watches the queue's head data and empty flag, pops one entry per frame, and serializes it LSB first. It sits between the software-facing transmit queue and the board pin.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clk cycles per UART bit (50 MHz / 115200). Legal range is ≥ 2.
- `DATA_WIDTH`, default 8: queue entry width. It is also the number of data bits per frame.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `enable`, in, 1: permits starting new frames.
- `q_data`, in, DATA_WIDTH: queue head entry. Combinational from the queue and valid whenever `q_empty`=0.
- `q_empty`, in, 1: queue empty flag.
- `q_remove`, out, 1: pop strobe, one cycle wide. The queue advances its head on the clk edge ending this cycle.
- `tx`, out, 1: serial line. Idles high.
- `busy`, out, 1: high while any frame bit (start, data or stop) is on `tx`.
- `frame_done`, out, 1: one-cycle pulse in the last cycle of each stop bit.
- `sent_count`, out, 16: number of completed frames. Wraps from 0xFFFF to 0.

## Operation
- The FSM is `IDLE`, `START`, `DATA`, `STOP`, held in registered state.
- Pop condition, `pop = enable & !q_empty & (state==IDLE | (state==STOP & bit_tick))`.
  - `q_remove` is a combinational decode of `pop`.
  - In the `pop` cycle, `q_data` is latched into the shift register, the baud counter is cleared, and the next state is `START`.
- `START`: `tx`=0 for CLKS_PER_BIT cycles, then go to `DATA` with bit index 0.
- `DATA`: `tx`=shreg[0]. On each bit_tick, shift right and increment the bit index. After DATA_WIDTH bits, go to `STOP`.
- `STOP`: `tx`=1 for CLKS_PER_BIT cycles.
  - On bit_tick, `frame_done` pulses and `sent_count` increments.
  - Next state is `START` if `pop` is true (back-to-back frames with no idle gap), otherwise `IDLE`.
- `tx` is registered and glitch-free.
- `busy` = (state != IDLE).
- Arithmetic and widths:
  - Baud counter is $clog2(CLKS_PER_BIT) bits. It counts 0..CLKS_PER_BIT-1, and bit_tick = (cnt == CLKS_PER_BIT-1).
  - Bit index is $clog2(DATA_WIDTH)+1 bits.
- Boundary conditions:
  - **Queue empty:** no pop occurs and the block stays in `IDLE` with `tx`=1. It never pops while `q_empty`=1.
  - **Queue refill during a frame:** has no effect until the `STOP` bit_tick.
  - **enable deasserted mid-frame:** the current frame completes, then the block returns to `IDLE`. No further pop occurs.
  - **Reset mid-frame:** `tx` goes to 1 and `busy` to 0 immediately. The in-flight byte is dropped and no extra pop is issued.
  - **Integration rule:** the connected queue must commit a pop whenever `q_remove`=1 and `q_empty`=0, including cycles with a simultaneous write. The queue's write must not take priority over the pop.

## Timing
- Reset values: `tx`=1, `busy`=0, `q_remove`=0, `frame_done`=0, `sent_count`=0, state=`IDLE`.
- Pop-to-line latency: `tx` falls in the cycle after the `q_remove` cycle.
- Frame length is (DATA_WIDTH+2)·CLKS_PER_BIT cycles.
- In back-to-back mode, consecutive `q_remove` pulses are exactly one frame apart.
- `frame_done` coincides with the last stop cycle. In back-to-back mode it is the same cycle as the next `q_remove`.
- `sent_count` updates on the edge ending the `frame_done` cycle.

## Structure
- Package `uart_pkg` holds:
  - `tx_state_t`, the enum {IDLE, START, DATA, STOP}.
  - `UART_DEFAULT_CLKS_PER_BIT`=434.
- Sub-module `uart_baud_tick` (parameter CLKS_PER_BIT; ports clk, rst_n, clear, tick) contains the restartable bit-period counter.
- The top level contains the FSM, shift register, pop decode and frame counter.

## Test plan
Use CLKS_PER_BIT=4, DATA_WIDTH=8, so one frame is 40 cycles.
- **Reset:** hold rst_n=0 with enable=1 and q_empty=0. Expect `tx`=1, `busy`=0, `q_remove`=0, `sent_count`=0 throughout. There is a single pop within 1 cycle after release.
- **Single byte:** queue holds 0xA5, enable=1. Expect:
  - One `q_remove` pulse.
  - `tx` = 0×4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1×4 cycles.
  - `frame_done` in cycle 40, `sent_count`=1, then `IDLE`.
- **Back-to-back:** queue holds 0x01, 0x80, 0xFF. Expect:
  - Three `q_remove` pulses 40 cycles apart.
  - `busy` continuously high for 120 cycles, with no idle-high gap between frames.
  - `sent_count`=3.
- **Empty:** q_empty=1 and enable=1 for 200 cycles. Expect no `q_remove`, `tx`=1, `busy`=0.
- **Enable drop:** deassert enable in data bit 2 with q_empty=0. The frame completes (40 cycles total) and no further `q_remove` is issued. Reasserting enable pops the next entry within 1 cycle.
- **Reset mid-frame:** pulse rst_n=0 during data bit 3 of 0x3C. `tx`=1 and `busy`=0 immediately and `sent_count`=0. After release with the queue non-empty, a fresh pop occurs and a full 40-cycle frame follows.
